// File: rtl/cpu_seq.sv
// Multi-cycle sequencer for the 8-bit accumulator datapath: instruction phasing,
// dmem port arbitration with an external requester, run/step/halt and counters.
module cpu_seq #(
    parameter int EXT_CYC = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt_op,
    input  logic             cu_wmem,
    input  logic             cu_wacc,
    input  logic             ext_req,
    input  logic             ext_we,
    output logic             ir_ld,
    output logic             pc_en,
    output logic             acc_we,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ext_gnt,
    output logic             ext_done,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_EXT    = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0]       EXT_LAST = 4'(EXT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0] ret_state;
    logic       step_pend;
    logic [3:0] ext_cnt;
    logic       in_ext;
    logic       active;

    assign in_ext   = (state == S_EXT);
    assign active   = (state >= S_FETCH) && (state <= S_EXT);

    // All strobes decode from registered state so each is exactly one phase wide.
    assign ir_ld    = (state == S_FETCH);
    assign pc_en    = (state == S_WB);
    assign acc_we   = (state == S_EXEC) && cu_wacc;
    assign mem_we   = ((state == S_EXEC) && cu_wmem) || (in_ext && (ext_cnt == 4'd0) && ext_we);
    assign mem_sel  = in_ext;
    assign ext_gnt  = in_ext;
    assign ext_done = in_ext && (ext_cnt == EXT_LAST);
    assign halted   = (state == S_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            step_pend <= 1'b0;
            ext_cnt   <= 4'd0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (active && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + CNT_ONE;

            case (state)
                S_IDLE: begin
                    if (ext_req) begin
                        // A same-cycle step is remembered and executed once EXT returns here.
                        state     <= S_EXT;
                        ret_state <= S_IDLE;
                        ext_cnt   <= 4'd0;
                        if (step && !run)
                            step_pend <= 1'b1;
                    end else if (run) begin
                        state <= S_FETCH;
                    end else if (step || step_pend) begin
                        state     <= S_FETCH;
                        step_pend <= 1'b1;
                    end
                end
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= halt_op ? S_HALT : S_EXEC;
                S_EXEC:   state <= S_WB;
                S_WB: begin
                    if (instr_cnt != '1)
                        instr_cnt <= instr_cnt + CNT_ONE;
                    // The stepped instruction retires here, so the pending step is consumed on every path.
                    step_pend <= 1'b0;
                    if (ext_req) begin
                        state     <= S_EXT;
                        ret_state <= (run && !step_pend) ? S_FETCH : S_IDLE;
                        ext_cnt   <= 4'd0;
                    end else if (step_pend) begin
                        state <= S_IDLE;
                    end else if (run) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_EXT: begin
                    if (ext_cnt == EXT_LAST) begin
                        state   <= ret_state;
                        ext_cnt <= 4'd0;
                    end else begin
                        ext_cnt <= ext_cnt + 4'd1;
                    end
                end
                S_HALT: begin
                    if (ext_req) begin
                        state     <= S_EXT;
                        ret_state <= S_HALT;
                        ext_cnt   <= 4'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
Multi-cycle sequencer for the 8-bit accumulator datapath (pc, imem, ir, cu, alu, acc, dmem).
- Splits each instruction into FETCH/DECODE/EXEC/WB phases and gates the ir load, acc write, dmem write and pc advance.
- Arbitrates the single dmem port between the datapath and an external loader/debug requester, at instruction boundaries only.
- Provides run/step/halt control and performance counters.

Parameters:
EXT_CYC, 1, cycles an external dmem transaction holds the port (1..15)
CNT_W, 16, width of cycle_cnt and instr_cnt

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = free-run instructions
step  in  1  single-cycle pulse; executes exactly one instruction when run=0
halt_op  in  1  cu decode: current ir holds HALT
cu_wmem  in  1  cu decode: instruction writes dmem
cu_wacc  in  1  cu decode: instruction writes acc
ext_req  in  1  external dmem access request (level, held until ext_done)
ext_we  in  1  external request is a write
ir_ld  out  1  load ir from imem
pc_en  out  1  advance/branch pc (pc takes cu pc mode)
acc_we  out  1  acc write enable
mem_we  out  1  dmem write enable (owner selected by mem_sel)
mem_sel  out  1  0 = datapath owns dmem, 1 = external owns dmem
ext_gnt  out  1  external access in progress
ext_done  out  1  one-cycle pulse, last cycle of external access
halted  out  1  sequencer in HALT
state  out  3  current FSM state encoding
cycle_cnt  out  CNT_W  active cycles
instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, counters 0, step_pend=0, ret_state=IDLE. This takes effect mid-instruction or mid-EXT with no completion pulse.
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, EXT=5, HALT=6. Values 7+ go to IDLE next cycle.
- All strobes (ir_ld, pc_en, acc_we, mem_we, ext_done) are Moore outputs decoded from registered state. They are one cycle wide.
- IDLE:
  - ext_req → EXT with ret_state=IDLE.
  - Else if run → FETCH.
  - Else if step → FETCH with step_pend=1.
  - ext_req has priority over run/step. A step arriving on the same cycle as ext_req is latched into step_pend and executed after EXT.
- step while run=1, or while not in IDLE, is ignored unless latched as above.
- FETCH: ir_ld=1 → DECODE.
- DECODE: no strobes. halt_op=1 → HALT, with no retire and no pc_en. Otherwise → EXEC.
- EXEC: acc_we=cu_wacc, mem_we=cu_wmem, mem_sel=0 → WB.
- WB: pc_en=1; instr_cnt+1 (saturating). Boundary decision:
  - ext_req → EXT, ret_state = FETCH if (run & ~step_pend) else IDLE.
  - Else step_pend → IDLE, clear step_pend.
  - Else run → FETCH.
  - Else → IDLE.
- EXT:
  - mem_sel=1, ext_gnt=1.
  - mem_we=ext_we on the first EXT cycle only.
  - Internal counter runs 0..EXT_CYC-1; ext_done=1 on the last cycle, then → ret_state.
  - From IDLE with step_pend=1, the return is IDLE, which then takes FETCH because step_pend is set.
  - Dropping ext_req mid-EXT does not abort the transaction.
- HALT: halted=1, no strobes. Exits only via reset. ext_req is still serviced (EXT with ret_state=HALT). run and step are ignored.
- cycle_cnt increments every cycle the state is FETCH..EXT and saturates at all-ones. instr_cnt also saturates.
- mem_sel=0 in every state except EXT, so the datapath never sees a foreign write.

Test Plan:
- Reset then run=1, no ext_req, halt_op=0 → state sequence 1,2,3,4,1…; ir_ld and pc_en each pulse once per 4 cycles; instr_cnt=3 after 12 cycles; cycle_cnt=12.
- run=0, step pulse in IDLE with cu_wacc=1 → exactly one FETCH..WB; acc_we high only in EXEC; return to IDLE; instr_cnt=1; a second step while in DECODE is ignored.
- run=1, ext_req asserted during EXEC, EXT_CYC=3, ext_we=1 → WB completes, then EXT for 3 cycles with mem_we=1 only in the first, ext_done on the third, mem_sel=1 throughout, then FETCH.
- halt_op=1 in DECODE → HALT, halted=1, instr_cnt unchanged, no pc_en. run toggling has no effect. ext_req is serviced and returns to HALT.
- Assert reset low mid-EXT (cycle 2 of 3) → all outputs 0 asynchronously, no ext_done. After release the sequencer is in IDLE with counters 0.
